// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control block.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_e;

  localparam int unsigned DRAIN_CYCLES = 3;
  localparam int unsigned CNT_W        = $clog2(DRAIN_CYCLES + 1);
  localparam logic [4:0]  REG_ZERO     = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
    logic exmem_write;
    logic memwb_bubble;
    logic dmem_req;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic ctrl_t ctrl_default(input logic dmem_req);
    ctrl_t c;
    c             = CTRL_IDLE;
    c.pc_write    = 1'b1;
    c.ifid_write  = 1'b1;
    c.idex_write  = 1'b1;
    c.exmem_write = 1'b1;
    c.dmem_req    = dmem_req;
    return c;
  endfunction

  // Front of the pipe frozen, MEM/WB fed a bubble while memory is busy.
  function automatic ctrl_t ctrl_mem_stall(input logic dmem_req);
    ctrl_t c;
    c              = CTRL_IDLE;
    c.memwb_bubble = 1'b1;
    c.dmem_req     = dmem_req;
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational load-use detector: EX load destination vs. ID source registers.
module pipe_hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 2
) (
  input  logic                    idex_memread,
  input  logic [4:0]              idex_rt,
  input  logic [NUM_SRC-1:0][4:0] ifid_src,
  output logic                    load_use
);

  logic [NUM_SRC-1:0] hit;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    assign hit[s] = (ifid_src[s] == idex_rt);
  end

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = idex_memread && (idex_rt != REG_ZERO) && (|hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/halt controller. Optional stall-cycle counter under PIPE_PERF_CNT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        I_IDEX_MemRead,
  input  logic [4:0]  I_IDEX_Rt,
  input  logic [4:0]  I_IFID_Rs,
  input  logic [4:0]  I_IFID_Rt,
  input  logic        I_Branch_Taken,
  input  logic        I_EXMEM_MemReq,
  input  logic        I_DMEM_Ready,
  input  logic        I_Halt,
  output logic        O_PC_Write,
  output logic        O_IFID_Write,
  output logic        O_IFID_Flush,
  output logic        O_IDEX_Write,
  output logic        O_IDEX_Flush,
  output logic        O_EXMEM_Write,
  output logic        O_MEMWB_Bubble,
  output logic        O_DMEM_Req,
  output logic        O_Halted,
  output logic [31:0] O_Stall_Cycles
);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   drain_cnt, drain_cnt_nxt;
  logic               halted_q;
  logic               load_use;
  logic               mem_stall;
  ctrl_t              ctrl;

  pipe_hazard_detect #(.NUM_SRC(2)) u_hazard (
    .idex_memread (I_IDEX_MemRead),
    .idex_rt      (I_IDEX_Rt),
    .ifid_src     ({I_IFID_Rt, I_IFID_Rs}),
    .load_use     (load_use)
  );

  assign mem_stall = I_EXMEM_MemReq && !I_DMEM_Ready;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= RUN;
      drain_cnt <= '0;
      halted_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      halted_q  <= (state_nxt == HALTED);
    end
  end

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    ctrl          = CTRL_IDLE;
    case (state)
      RUN: begin
        ctrl = ctrl_default(I_EXMEM_MemReq);
        if (mem_stall) begin
          ctrl      = ctrl_mem_stall(I_EXMEM_MemReq);
          state_nxt = MEM_WAIT;
        end else if (I_Branch_Taken) begin
          ctrl.ifid_flush = 1'b1;
          ctrl.idex_flush = 1'b1;
        end else if (I_Halt) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = CNT_W'(DRAIN_CYCLES);
        end else if (load_use) begin
          ctrl.pc_write   = 1'b0;
          ctrl.ifid_write = 1'b0;
          ctrl.idex_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Branch/halt still present on release are picked up in RUN next cycle.
        if (I_DMEM_Ready) begin
          ctrl      = ctrl_default(I_EXMEM_MemReq);
          state_nxt = RUN;
        end else begin
          ctrl = ctrl_mem_stall(I_EXMEM_MemReq);
        end
      end
      DRAIN: begin
        if (mem_stall) begin
          ctrl = ctrl_mem_stall(1'b0);
        end else begin
          ctrl            = ctrl_default(1'b0);
          ctrl.pc_write   = 1'b0;
          ctrl.ifid_flush = 1'b1;
          drain_cnt_nxt   = drain_cnt - CNT_W'(1);
          if (drain_cnt <= CNT_W'(1)) begin
            drain_cnt_nxt = '0;
            state_nxt     = HALTED;
          end
        end
      end
      HALTED: ctrl = CTRL_IDLE;
      default: state_nxt = RUN;
    endcase
    if (RESET) ctrl = CTRL_IDLE;
  end

  assign O_PC_Write     = ctrl.pc_write;
  assign O_IFID_Write   = ctrl.ifid_write;
  assign O_IFID_Flush   = ctrl.ifid_flush;
  assign O_IDEX_Write   = ctrl.idex_write;
  assign O_IDEX_Flush   = ctrl.idex_flush;
  assign O_EXMEM_Write  = ctrl.exmem_write;
  assign O_MEMWB_Bubble = ctrl.memwb_bubble;
  assign O_DMEM_Req     = ctrl.dmem_req;
  assign O_Halted       = halted_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      stall_cnt <= '0;
    else if (state != HALTED && !ctrl.pc_write && stall_cnt != 32'hFFFF_FFFF)
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign O_Stall_Cycles = stall_cnt;
`else
  assign O_Stall_Cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl; expected output words are hand-computed.
module tb_pipe_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        idex_memread, br, memreq, rdy, halt;
  logic [4:0]  idex_rt, ifid_rs, ifid_rt;
  logic        pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, bubble, dreq, halted;
  logic [31:0] stall_cycles;
  logic [8:0]  outs;

  int nvec = 0;
  int nerr = 0;

  // {PC_W, IFID_W, IFID_F, IDEX_W, IDEX_F, EXMEM_W, BUBBLE, DMEM_REQ, HALTED}
  localparam logic [8:0] O_ZERO = 9'b000000000;
  localparam logic [8:0] O_DEF  = 9'b110101000;
  localparam logic [8:0] O_DEFM = 9'b110101010;
  localparam logic [8:0] O_MSTL = 9'b000000110;
  localparam logic [8:0] O_LU   = 9'b000111000;
  localparam logic [8:0] O_BR   = 9'b111111000;
  localparam logic [8:0] O_DRN  = 9'b011101000;
  localparam logic [8:0] O_DRNS = 9'b000000100;
  localparam logic [8:0] O_HLT  = 9'b000000001;

`ifdef PIPE_PERF_CNT_EN
  localparam logic [31:0] EXP_STALL4 = 32'd4;
`else
  localparam logic [31:0] EXP_STALL4 = 32'd0;
`endif

  always #5 CLK = ~CLK;

  pipe_ctrl dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .I_IDEX_MemRead (idex_memread),
    .I_IDEX_Rt      (idex_rt),
    .I_IFID_Rs      (ifid_rs),
    .I_IFID_Rt      (ifid_rt),
    .I_Branch_Taken (br),
    .I_EXMEM_MemReq (memreq),
    .I_DMEM_Ready   (rdy),
    .I_Halt         (halt),
    .O_PC_Write     (pc_w),
    .O_IFID_Write   (ifid_w),
    .O_IFID_Flush   (ifid_f),
    .O_IDEX_Write   (idex_w),
    .O_IDEX_Flush   (idex_f),
    .O_EXMEM_Write  (exmem_w),
    .O_MEMWB_Bubble (bubble),
    .O_DMEM_Req     (dreq),
    .O_Halted       (halted),
    .O_Stall_Cycles (stall_cycles)
  );

  assign outs = {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, bubble, dreq, halted};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    idex_memread = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
    br = 0; memreq = 0; rdy = 0; halt = 0;
  endtask

  // Inputs are set just after a falling edge; check, then move to the next falling edge.
  task automatic vec(input string tag, input logic [8:0] exp);
    #1;
    chk(tag, {23'd0, outs}, {23'd0, exp});
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    clr();
    #1;
    chk("rst_outs", {23'd0, outs}, 32'd0);
    chk("rst_cnt", stall_cycles, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    clr();
    do_reset();
    vec("run_default", O_DEF);

    // load-use
    idex_memread = 1; idex_rt = 5'd8; ifid_rs = 5'd8;  vec("lu_rs", O_LU);
    clr();                                             vec("lu_release", O_DEF);
    idex_memread = 1; idex_rt = 5'd0; ifid_rs = 5'd0;  vec("lu_r0", O_DEF);
    idex_memread = 1; idex_rt = 5'd9; ifid_rt = 5'd9;  vec("lu_rt", O_LU);
    idex_memread = 0;                                  vec("lu_noload", O_DEF);

    // branch over load-use, then memory stall over both
    clr(); br = 1; idex_memread = 1; idex_rt = 5'd8; ifid_rs = 5'd8;
    vec("br_over_lu", O_BR);
    memreq = 1; rdy = 0;   vec("mem_over_br", O_MSTL);
    rdy = 1;               vec("br_held_release", O_DEFM);
    memreq = 0; rdy = 0;   vec("br_reeval", O_BR);
    clr();                 vec("br_done", O_DEF);

    // memory wait, 4 stalled cycles
    do_reset();
    memreq = 1; rdy = 0;
    for (int i = 0; i < 4; i++) vec($sformatf("mwait_%0d", i), O_MSTL);
    rdy = 1;               vec("mwait_release", O_DEFM);
    clr();                 vec("mwait_run", O_DEF);
    chk("mwait_cnt", stall_cycles, EXP_STALL4);
    memreq = 1; rdy = 1;   vec("mem_ready_nostall", O_DEFM);
    clr();

    // reset in second MEM_WAIT cycle
    do_reset();
    memreq = 1; rdy = 0;   vec("mw_c1", O_MSTL);
    #1;
    chk("mw_c2", {23'd0, outs}, {23'd0, O_MSTL});
    RESET = 1'b1;
    #1;
    chk("mw_rst_outs", {23'd0, outs}, 32'd0);
    chk("mw_rst_cnt", stall_cycles, 32'd0);
    @(negedge CLK);
    RESET = 1'b0; clr(); br = 1;
    vec("post_rst_run", O_BR);
    clr();                 vec("post_rst_def", O_DEF);
    chk("post_rst_cnt", stall_cycles, 32'd0);

    // branch beats halt
    halt = 1; br = 1;      vec("br_over_halt", O_BR);
    clr();                 vec("no_drain", O_DEF);

    // halt beats load-use, drain with a frozen cycle, then halted
    halt = 1; idex_memread = 1; idex_rt = 5'd8; ifid_rs = 5'd8;
    vec("halt_cycle", O_DEF);
    clr();                 vec("drain_3", O_DRN);
    memreq = 1; rdy = 0;   vec("drain_mstall", O_DRNS);
    clr();                 vec("drain_2", O_DRN);
                           vec("drain_1", O_DRN);
    br = 1; idex_memread = 1; idex_rt = 5'd8; ifid_rs = 5'd8; memreq = 1;
    vec("halted_0", O_HLT);
    vec("halted_1", O_HLT);
    chk("halt_cnt", stall_cycles, EXP_STALL4);

    do_reset();
    vec("halt_exit_rst", O_DEF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
